gray_monitor: RTL and testbench

Decoder-side companion to the team's 3-bit Gray counter. It samples a Gray-coded position bus on a strobe and converts it to binary. It checks that each new sample is a legal single-bit step from the previous one and reports step direction, wrap-around and coding faults. It sits on the receive side of any Gray-coded counter or position source, for example a counter crossing into this block's clock domain already synchronised.

---
 rtl/gray_monitor_pkg.sv | 12 +
 rtl/gray_monitor_gray_to_bin.sv | 17 +
 rtl/gray_monitor.sv | 140 ++++++++++++++
 tb/tb_gray_monitor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_monitor_pkg.sv
// Shared constants for the Gray-code monitor: default widths and FSM state encodings.
package gray_monitor_pkg;

    localparam int GM_WIDTH_DEFAULT  = 3;
    localparam int GM_WRAP_W_DEFAULT = 4;

    // 2'd3 is unreachable; the FSM recovers from it to IDLE.
    localparam logic [1:0] GM_IDLE  = 2'd0;
    localparam logic [1:0] GM_TRACK = 2'd1;
    localparam logic [1:0] GM_FAULT = 2'd2;

endpackage

// File: rtl/gray_monitor_gray_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin[WIDTH-1] = gray[WIDTH-1];

    generate
        for (genvar gi = WIDTH - 2; gi >= 0; gi--) begin : g_xor_chain
            assign bin[gi] = bin[gi+1] ^ gray[gi];
        end
    endgenerate

endmodule

// File: rtl/gray_monitor.sv
// Samples a Gray-coded position on Valid, decodes it and checks that successive samples
// differ by one bit, reporting step direction, forward wraps and coding faults.
module gray_monitor
    import gray_monitor_pkg::*;
#(
    parameter int WIDTH  = GM_WIDTH_DEFAULT,
    parameter int WRAP_W = GM_WRAP_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Valid,
    input  logic [WIDTH-1:0]  Gray_in,
    input  logic              Clear,
    output logic [WIDTH-1:0]  Binary,
    output logic              Step,
    output logic              Dir,
    output logic              Locked,
    output logic              Overflow,
    output logic              Error,
    output logic [WRAP_W-1:0] Wraps
);

    logic [1:0]        state_reg, state_next;
    logic [WIDTH-1:0]  prev_gray_reg, prev_gray_next;
    logic [WIDTH-1:0]  bin_reg, bin_next;
    logic              step_reg, step_next;
    logic              dir_reg, dir_next;
    logic              locked_reg, locked_next;
    logic              overflow_reg, overflow_next;
    logic              error_reg, error_next;
    logic [WRAP_W-1:0] wraps_reg, wraps_next;

    logic [WIDTH-1:0] new_bin;
    logic [WIDTH-1:0] diff;
    logic             single_bit;
    logic             is_up;
    logic             is_fwd_wrap;

    gray_to_bin #(
        .WIDTH(WIDTH)
    ) u_decode (
        .gray(Gray_in),
        .bin (new_bin)
    );

    // A legal step flips exactly one Gray bit: nonzero and a power of two.
    assign diff        = Gray_in ^ prev_gray_reg;
    assign single_bit  = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    assign is_up       = (new_bin == bin_reg + WIDTH'(1));
    assign is_fwd_wrap = (bin_reg == {WIDTH{1'b1}}) && (new_bin == '0);

    always_comb begin
        state_next     = state_reg;
        prev_gray_next = prev_gray_reg;
        bin_next       = bin_reg;
        step_next      = 1'b0;
        dir_next       = dir_reg;
        locked_next    = locked_reg;
        overflow_next  = overflow_reg;
        error_next     = error_reg;
        wraps_next     = wraps_reg;

        if (Clear) begin
            state_next    = GM_IDLE;
            locked_next   = 1'b0;
            overflow_next = 1'b0;
            error_next    = 1'b0;
            wraps_next    = '0;
        end else begin
            case (state_reg)
                GM_IDLE: begin
                    if (Valid) begin
                        prev_gray_next = Gray_in;
                        bin_next       = new_bin;
                        locked_next    = 1'b1;
                        state_next     = GM_TRACK;
                    end
                end
                GM_TRACK: begin
                    if (Valid && (diff != '0)) begin
                        if (single_bit) begin
                            prev_gray_next = Gray_in;
                            bin_next       = new_bin;
                            step_next      = 1'b1;
                            dir_next       = is_up;
                            if (is_fwd_wrap) begin
                                overflow_next = 1'b1;
                                if (wraps_reg != {WRAP_W{1'b1}}) begin
                                    wraps_next = wraps_reg + WRAP_W'(1);
                                end
                            end
                        end else begin
                            error_next = 1'b1;
                            state_next = GM_FAULT;
                        end
                    end
                end
                GM_FAULT: begin
                    state_next = GM_FAULT;
                end
                default: begin
                    state_next = GM_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg     <= GM_IDLE;
            prev_gray_reg <= '0;
            bin_reg       <= '0;
            step_reg      <= 1'b0;
            dir_reg       <= 1'b0;
            locked_reg    <= 1'b0;
            overflow_reg  <= 1'b0;
            error_reg     <= 1'b0;
            wraps_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            prev_gray_reg <= prev_gray_next;
            bin_reg       <= bin_next;
            step_reg      <= step_next;
            dir_reg       <= dir_next;
            locked_reg    <= locked_next;
            overflow_reg  <= overflow_next;
            error_reg     <= error_next;
            wraps_reg     <= wraps_next;
        end
    end

    assign Binary   = bin_reg;
    assign Step     = step_reg;
    assign Dir      = dir_reg;
    assign Locked   = locked_reg;
    assign Overflow = overflow_reg;
    assign Error    = error_reg;
    assign Wraps    = wraps_reg;

endmodule

// File: tb/tb_gray_monitor.sv
// Self-checking bench for gray_monitor: directed scenarios plus randomized traffic against a behavioural model.
module tb_gray_monitor;

    logic       Clk;
    logic       Reset_n;
    logic       Valid;
    logic [2:0] Gray_in;
    logic       Clear;
    logic [2:0] Binary;
    logic       Step;
    logic       Dir;
    logic       Locked;
    logic       Overflow;
    logic       Error;
    logic [3:0] Wraps;

    int checks   = 0;
    int failures = 0;

    // Reference model state, in plain integers.
    int m_bin, m_prev_g, m_wraps;
    bit m_locked, m_fault, m_step, m_dir, m_ovf, m_err;

    gray_monitor #(
        .WIDTH (3),
        .WRAP_W(4)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Valid   (Valid),
        .Gray_in (Gray_in),
        .Clear   (Clear),
        .Binary  (Binary),
        .Step    (Step),
        .Dir     (Dir),
        .Locked  (Locked),
        .Overflow(Overflow),
        .Error   (Error),
        .Wraps   (Wraps)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int gray_enc(input int b);
        return b ^ (b >> 1);
    endfunction

    // Decode by searching for the binary value whose Gray code matches.
    function automatic int gray_dec(input int g);
        for (int b = 0; b < 8; b++) begin
            if (gray_enc(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic check_value(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_all();
        check_value("binary",   int'(Binary),   m_bin);
        check_value("step",     int'(Step),     int'(m_step));
        check_value("dir",      int'(Dir),      int'(m_dir));
        check_value("locked",   int'(Locked),   int'(m_locked));
        check_value("overflow", int'(Overflow), int'(m_ovf));
        check_value("error",    int'(Error),    int'(m_err));
        check_value("wraps",    int'(Wraps),    m_wraps);
    endtask

    task automatic model_reset();
        m_bin = 0; m_prev_g = 0; m_wraps = 0;
        m_locked = 0; m_fault = 0; m_step = 0; m_dir = 0; m_ovf = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input int g, input bit c);
        int nb;
        m_step = 0;
        if (c) begin
            m_locked = 0; m_fault = 0; m_ovf = 0; m_err = 0; m_wraps = 0;
        end else if (v && !m_fault) begin
            nb = gray_dec(g);
            if (!m_locked) begin
                m_prev_g = g; m_bin = nb; m_locked = 1;
            end else if ($countones(g ^ m_prev_g) == 1) begin
                m_dir = (nb == (m_bin + 1) % 8);
                if (m_bin == 7 && nb == 0) begin
                    m_ovf = 1;
                    if (m_wraps < 15) m_wraps++;
                end
                m_bin = nb; m_prev_g = g; m_step = 1;
            end else if (g != m_prev_g) begin
                m_err = 1; m_fault = 1;
            end
        end
    endtask

    task automatic do_cycle(input bit v, input int g, input bit c);
        @(negedge Clk);
        Valid = v; Gray_in = 3'(g); Clear = c;
        @(posedge Clk);
        model_step(v, g, c);
        #1;
        check_all();
        $display("txn valid=%0b gray=%03b clear=%0b -> bin=%0d step=%0b dir=%0b lock=%0b ovf=%0b err=%0b wraps=%0d",
                 v, 3'(g), c, Binary, Step, Dir, Locked, Overflow, Error, Wraps);
    endtask

    // Asynchronous reset landing between clock edges; outputs must clear before any edge.
    task automatic async_reset_check();
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        $display("txn async reset asserted between edges");
        @(posedge Clk);
        #1;
        check_all();
        @(negedge Clk);
        Reset_n = 1'b1;
        Valid = 1'b0; Clear = 1'b0;
    endtask

    task automatic forward_walk(input int steps);
        for (int i = 0; i < steps; i++) do_cycle(1, gray_enc((m_bin + 1) % 8), 0);
    endtask

    initial begin
        int r, s, g;
        bit v, c;
        Reset_n = 1'b0; Valid = 1'b0; Gray_in = 3'b000; Clear = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all();
        $display("txn reset held");
        @(negedge Clk);
        Reset_n = 1'b1;

        // First lock at 011 decodes to 2.
        do_cycle(1, 3'b011, 0);
        do_cycle(0, 3'b000, 0);

        // Forward walk through all codes with a wrap.
        do_cycle(0, 0, 1);
        do_cycle(1, 3'b000, 0);
        forward_walk(8);

        // Down step 011 -> 001.
        do_cycle(0, 0, 1);
        do_cycle(1, 3'b011, 0);
        do_cycle(1, 3'b001, 0);
        // Down wrap 000 -> 100 leaves Overflow alone.
        do_cycle(1, 3'b000, 0);
        do_cycle(1, 3'b100, 0);

        // Illegal jump, ignored sample while faulted, then Clear.
        do_cycle(0, 0, 1);
        do_cycle(1, 3'b000, 0);
        do_cycle(1, 3'b011, 0);
        do_cycle(1, 3'b001, 0);
        do_cycle(0, 0, 1);

        // Clear together with Valid in TRACK after an overflow.
        do_cycle(1, 3'b000, 0);
        forward_walk(8);
        do_cycle(1, 3'b001, 1);
        do_cycle(1, 3'b001, 0);

        // Seventeen forward wraps saturate the wrap counter.
        do_cycle(0, 0, 1);
        do_cycle(1, 3'b000, 0);
        forward_walk(17 * 8);

        async_reset_check();

        // Randomized traffic: mostly legal steps, some repeats, illegal jumps, clears and resets.
        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, 99);
            if (r == 0) begin
                async_reset_check();
            end else begin
                c = (r < 5);
                v = (r < 85);
                s = $urandom_range(0, 9);
                if (!m_locked || s == 9) g = $urandom_range(0, 7);
                else if (s < 5) g = gray_enc((m_bin + 1) % 8);
                else if (s < 8) g = gray_enc((m_bin + 7) % 8);
                else g = m_prev_g;
                do_cycle(v, g, c);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
